mips_debug_frame_tx: RTL and testbench

MIPS_DEBUG_FRAME_TX -- requirements
Module: mips_debug_frame_tx

---
 rtl/mips_debug_pkg.sv | 40 ++++
 rtl/mips_debug_frame_tx.sv | 105 ++++++++++
 tb/tb_mips_debug_frame_tx.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_debug_pkg.sv
// rtl/mips_debug_pkg.sv - shared debug-link frame, select and state definitions
package mips_debug_pkg;

   typedef enum logic [1:0] {
      KIND_IDLE = 2'b00,
      KIND_DATA = 2'b01,
      KIND_EOD  = 2'b10,
      KIND_MODE = 2'b11
   } frame_kind_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_EOD,
      ST_MODE
   } tx_state_t;

   localparam int FRAME_KIND_LSB  = 30;
   localparam int FRAME_IDX_LSB   = 16;
   localparam int FRAME_IDX_W     = 8;
   localparam int FRAME_PAYLOAD_W = 16;

   // Registers occupy 6'b0xxxxx; single-word specials sit at 6'b1000xx.
   localparam logic [5:0] SEL_PC         = 6'b100000;
   localparam logic [5:0] SEL_DMEM       = 6'b100001;
   localparam logic [5:0] SEL_IMEM       = 6'b100010;
   localparam logic [5:0] SEL_LATCH_BASE = 6'b100100;

   function automatic logic sel_is_word(input logic [5:0] sel);
      return !sel[5] || (sel[5:2] == 4'b1000);
   endfunction

   function automatic logic [31:0] make_frame(input frame_kind_t kind,
                                              input logic [FRAME_IDX_W-1:0] idx,
                                              input logic [FRAME_PAYLOAD_W-1:0] payload);
      return {kind, 6'b0, idx, payload};
   endfunction

endpackage

// File: rtl/mips_debug_frame_tx.sv
// rtl/mips_debug_frame_tx.sv - chunks a word or latch strip into acked debug frames
module mips_debug_frame_tx
   import mips_debug_pkg::*;
#(
   parameter int NB_FRAME = 32,
   parameter int NB_CHUNK = 16,
   parameter int NB_STRIP = 256,
   parameter int NB_WORD  = 32
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_read_request,
   input  logic [5:0]          i_request_select,
   input  logic                i_mode_request,
   input  logic                i_mode,
   input  logic [NB_WORD-1:0]  i_word_data,
   input  logic [NB_STRIP-1:0] i_strip_data,
   input  logic                i_ack,
   output logic [NB_FRAME-1:0] o_frame,
   output logic                o_busy
);

   localparam int STRIP_CHUNKS = NB_STRIP / NB_CHUNK;
   localparam int IDX_W        = $clog2(STRIP_CHUNKS) + 1;
   localparam logic [IDX_W-1:0] WORD_LAST  = IDX_W'(NB_WORD / NB_CHUNK - 1);
   localparam logic [IDX_W-1:0] STRIP_LAST = IDX_W'(STRIP_CHUNKS - 1);

   tx_state_t             state_q, state_d;
   logic [NB_FRAME-1:0]   frame_q, frame_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [NB_STRIP-1:0]   buf_q, buf_d;
   logic                  word_sel_q, word_sel_d;
   logic [NB_STRIP-1:0]   src;
   logic [IDX_W-1:0]      last_idx;

   assign last_idx = word_sel_q ? WORD_LAST : STRIP_LAST;

   always_comb begin
      state_d    = state_q;
      frame_d    = frame_q;
      idx_d      = idx_q;
      buf_d      = buf_q;
      word_sel_d = word_sel_q;
      src        = word_sel_q ? NB_STRIP'(i_word_data) : i_strip_data;
      case (state_q)
         ST_IDLE: begin
            // A read wins over a coincident mode query; the query is dropped.
            if (i_read_request) begin
               word_sel_d = sel_is_word(i_request_select);
               state_d    = ST_LOAD;
            end else if (i_mode_request) begin
               frame_d = NB_FRAME'(make_frame(KIND_MODE, '0, {15'b0, i_mode}));
               state_d = ST_MODE;
            end
         end
         ST_LOAD: begin
            frame_d = NB_FRAME'(make_frame(KIND_DATA, '0,
                                           FRAME_PAYLOAD_W'(src[NB_CHUNK-1:0])));
            buf_d   = src >> NB_CHUNK;
            idx_d   = '0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            if (i_ack) begin
               idx_d = idx_q + 1'b1;
               if (idx_q == last_idx) begin
                  frame_d = NB_FRAME'(make_frame(KIND_EOD, FRAME_IDX_W'(idx_d), '0));
                  state_d = ST_EOD;
               end else begin
                  frame_d = NB_FRAME'(make_frame(KIND_DATA, FRAME_IDX_W'(idx_d),
                                                 FRAME_PAYLOAD_W'(buf_q[NB_CHUNK-1:0])));
                  buf_d   = buf_q >> NB_CHUNK;
               end
            end
         end
         ST_EOD, ST_MODE: begin
            if (i_ack) begin
               frame_d = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         frame_q    <= '0;
         idx_q      <= '0;
         buf_q      <= '0;
         word_sel_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         buf_q      <= buf_d;
         word_sel_q <= word_sel_d;
      end
   end

   assign o_frame = frame_q;
   assign o_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_debug_frame_tx.sv
// tb/tb_mips_debug_frame_tx.sv - self-checking bench for mips_debug_frame_tx
module tb_mips_debug_frame_tx;

   logic         i_clock = 1'b0;
   logic         i_reset = 1'b1;
   logic         i_read_request = 1'b0;
   logic [5:0]   i_request_select = '0;
   logic         i_mode_request = 1'b0;
   logic         i_mode = 1'b0;
   logic [31:0]  i_word_data = '0;
   logic [255:0] i_strip_data = '0;
   logic         i_ack = 1'b0;
   logic [31:0]  o_frame;
   logic         o_busy;

   int tests = 0;
   int fails = 0;

   mips_debug_frame_tx dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_read_request   (i_read_request),
      .i_request_select (i_request_select),
      .i_mode_request   (i_mode_request),
      .i_mode           (i_mode),
      .i_word_data      (i_word_data),
      .i_strip_data     (i_strip_data),
      .i_ack            (i_ack),
      .o_frame          (o_frame),
      .o_busy           (o_busy)
   );

   always #5 i_clock = ~i_clock;

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_is_word(input logic [5:0] s);
      return (s[5] == 1'b0) || (s[5:2] == 4'b1000);
   endfunction

   function automatic logic [255:0] rand_strip();
      logic [255:0] s;
      for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   // Reference: the expected frame list is built from the frame format rules.
   task automatic run_read(input logic [5:0] sel, input logic [31:0] word,
                           input logic [255:0] strip, input int hold_at,
                           input int abort_at, input bit stray, input bit with_mode);
      logic [255:0] src;
      logic [31:0]  exp_q[$];
      int           count;
      count = ref_is_word(sel) ? 2 : 16;
      src   = ref_is_word(sel) ? {224'b0, word} : strip;
      for (int n = 0; n < count; n++)
         exp_q.push_back({2'b01, 6'b0, 8'(n), src[16*n +: 16]});
      exp_q.push_back({2'b10, 6'b0, 8'(count), 16'h0});

      i_request_select = sel;
      i_word_data      = word;
      i_strip_data     = strip;
      i_read_request   = 1'b1;
      i_mode_request   = with_mode;
      i_ack            = stray;
      step();
      i_read_request = 1'b0;
      i_mode_request = 1'b0;
      chk("load_busy", {31'b0, o_busy}, 32'd1);
      chk("load_frame", o_frame, 32'h0);
      step();
      i_ack = 1'b0;
      chk("first_frame", o_frame, exp_q[0]);

      for (int n = 0; n <= count; n++) begin
         chk($sformatf("frame%0d", n), o_frame, exp_q[n]);
         chk($sformatf("busy%0d", n), {31'b0, o_busy}, 32'd1);
         if (n == abort_at) begin
            i_reset = 1'b1;
            step();
            i_reset = 1'b0;
            chk("abort_frame", o_frame, 32'h0);
            chk("abort_busy", {31'b0, o_busy}, 32'd0);
            return;
         end
         if (n == hold_at) begin
            for (int c = 0; c < 50; c++) begin
               i_strip_data   = rand_strip();
               i_word_data    = $urandom;
               i_read_request = 1'b1;
               i_mode_request = c[0];
               step();
               chk("hold_frame", o_frame, exp_q[n]);
               chk("hold_busy", {31'b0, o_busy}, 32'd1);
            end
            i_read_request = 1'b0;
            i_mode_request = 1'b0;
         end else begin
            repeat ($urandom_range(0, 2)) begin
               step();
               chk("gap_frame", o_frame, exp_q[n]);
            end
         end
         i_ack = 1'b1;
         if (n == count) begin
            i_read_request = 1'b1;
            i_mode_request = 1'b1;
         end
         step();
         i_ack          = 1'b0;
         i_read_request = 1'b0;
         i_mode_request = 1'b0;
      end
      chk("end_frame", o_frame, 32'h0);
      chk("end_busy", {31'b0, o_busy}, 32'd0);
      step();
      chk("no_queue_busy", {31'b0, o_busy}, 32'd0);
      chk("no_queue_frame", o_frame, 32'h0);
   endtask

   task automatic run_mode(input bit m);
      i_mode         = m;
      i_mode_request = 1'b1;
      step();
      i_mode_request = 1'b0;
      chk("mode_frame", o_frame, {2'b11, 29'b0, m});
      chk("mode_busy", {31'b0, o_busy}, 32'd1);
      repeat (3) begin
         step();
         chk("mode_hold", o_frame, {2'b11, 29'b0, m});
      end
      i_ack          = 1'b1;
      i_read_request = 1'b1;
      step();
      i_ack          = 1'b0;
      i_read_request = 1'b0;
      chk("mode_end_frame", o_frame, 32'h0);
      chk("mode_end_busy", {31'b0, o_busy}, 32'd0);
      step();
      chk("mode_no_queue", {31'b0, o_busy}, 32'd0);
   endtask

   initial begin
      logic [255:0] strip_a;
      for (int k = 0; k < 16; k++) strip_a[16*k +: 16] = 16'hA000 + 16'(k);

      i_word_data  = 32'h1234_5678;
      i_strip_data = rand_strip();
      i_read_request = 1'b1;
      i_mode_request = 1'b1;
      i_ack          = 1'b1;
      step();
      step();
      i_read_request = 1'b0;
      i_mode_request = 1'b0;
      i_ack          = 1'b0;
      chk("reset_frame", o_frame, 32'h0);
      chk("reset_busy", {31'b0, o_busy}, 32'd0);
      i_reset = 1'b0;

      run_read(6'b000101, 32'hDEADBEEF, '0, -1, -1, 1'b0, 1'b0);
      chk("reg_read_lit", {2'b01, 6'b0, 8'd1, 16'hDEAD}, 32'h4001DEAD);

      run_read(6'b100100, $urandom, strip_a, 3, -1, 1'b0, 1'b0);

      run_mode(1'b1);
      run_mode(1'b0);

      run_read(6'b100000, $urandom, rand_strip(), -1, -1, 1'b0, 1'b1);
      run_read(6'b111000, $urandom, rand_strip(), -1, -1, 1'b0, 1'b1);

      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      chk("stray_idle_frame", o_frame, 32'h0);
      chk("stray_idle_busy", {31'b0, o_busy}, 32'd0);
      run_read(6'b000011, $urandom, rand_strip(), -1, -1, 1'b1, 1'b0);
      run_read(6'b101100, $urandom, rand_strip(), -1, -1, 1'b1, 1'b0);

      run_read(6'b110000, $urandom, rand_strip(), -1, 7, 1'b0, 1'b0);
      run_read(6'b100010, $urandom, rand_strip(), -1, -1, 1'b0, 1'b0);

      for (int r = 0; r < 6; r++)
         run_read(6'($urandom_range(0, 63)), $urandom, rand_strip(), -1, -1,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
